// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory access unit.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  // Context captured on accept, used to shape the registered RAM word.
  typedef struct packed {
    logic       rd;
    logic [1:0] size;
    logic [1:0] off;
    logic       sgn;
  } resp_ctx_t;

  function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] store_lanes(input logic [WORD_W-1:0] data,
                                                    input logic [1:0] size);
    case (size)
      SZ_B:    store_lanes = {4{data[7:0]}};
      SZ_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] off,
                                                    input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_extend = {{24{sgn & b[7]}}, b};
      SZ_H:    load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_ram.sv
// Single-port synchronous RAM with byte-write enables and a registered read port.
module dmem_access_unit_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Read data only moves on a load, so it stays stable while a response is stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: byte/half/word loads and stores over valid/ready.
// Define DMEM_FAULT_EN to reject misaligned, reserved-size and out-of-range accesses.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IDX_W  = ADDR_W - 2;

  if (DATA_W != WORD_W) begin : g_width_check
    $error("dmem_access_unit: only DATA_W = 32 is supported");
  end

  state_t            state;
  resp_ctx_t         ctx;
  logic              accept;
  logic              fault_c;
  logic              ram_en;
  logic [1:0]        size_c;
  logic [1:0]        off_c;
  logic [IDX_W-1:0]  widx;
  logic [BE_W-1:0]   be;
  logic [WORD_W-1:0] wlanes;
  logic [WORD_W-1:0] ram_rdata;

  assign req_ready = (state == ST_IDLE) || resp_ready;
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[ADDR_W-1:2];

  // Request decode: effective size/offset and fault classification.
  always_comb begin
    size_c  = req_size;
    off_c   = req_addr[1:0];
    fault_c = 1'b0;
`ifdef DMEM_FAULT_EN
    fault_c = (req_size == SZ_RSV)
           || ((req_size == SZ_H) && req_addr[0])
           || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
           || (32'(widx) >= 32'(DEPTH_WORDS));
`else
    if (req_size == SZ_RSV) size_c = SZ_W;
    case (size_c)
      SZ_H:    off_c = {req_addr[1], 1'b0};
      SZ_W:    off_c = 2'b00;
      default: ;
    endcase
`endif
  end

  // A store coinciding with reset must not reach the array.
  assign ram_en = accept && !rst && !fault_c;
  assign be     = byte_en(size_c, off_c);
  assign wlanes = store_lanes(WORD_W'(req_wdata), size_c);

  dmem_access_unit_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_we),
    .be    (be),
    .addr  (RAM_AW'(widx)),
    .wdata (wlanes),
    .rdata (ram_rdata)
  );

  // FSM and response context; all response state moves only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      resp_fault <= 1'b0;
      ctx        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_RESP;
        ST_RESP: if (!accept && resp_ready) state <= ST_IDLE;
      endcase
      if (accept) begin
        resp_fault <= fault_c;
        ctx        <= '{rd: !req_we && !fault_c, size: size_c, off: off_c, sgn: req_signed};
      end
    end
  end

  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = ctx.rd ? DATA_W'(load_extend(ram_rdata, ctx.size, ctx.off, ctx.sgn))
                             : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit; expectations queued at issue, checked by a monitor.
module tb_dmem_access_unit;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;

  typedef struct packed {
    logic [7:0]  id;
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   vectors = 0, miscompares = 0, cyc = 0, id_n = 0;

  dmem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every consumed response is compared to the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid && resp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got rdata=%h fault=%b, want no response", resp_rdata, resp_fault);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (resp_rdata !== e.rdata || resp_fault !== e.fault) begin
          miscompares++;
          $display("FAIL resp_%0d: got rdata=%h fault=%b, want rdata=%h fault=%b",
                   e.id, resp_rdata, resp_fault, e.rdata, e.fault);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ef, input bit expect_resp);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=0 for addr %h, want 1", a);
    end else if (expect_resp) begin
      exp_q.push_back('{id: 8'(id_n), fault: ef, rdata: er});
    end
    id_n++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // word store/load and load latency
    issue(1'b1, W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("lw_latency_valid", 32'(resp_valid), 32'd1);
    @(posedge clk);
    #1;

    // byte store into lane 3, signed/unsigned byte loads
    issue(1'b1, B, 1'b0, 12'h013, 32'h00000080, 32'h0, 1'b0, 1'b1);
    issue(1'b0, B, 1'b1, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, B, 1'b0, 12'h013, 32'h0, 32'h00000080, 1'b0, 1'b1);
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);

    // halfword store into the upper half
    issue(1'b1, W, 1'b0, 12'h020, 32'h00000000, 32'h0, 1'b0, 1'b1);
    issue(1'b1, H, 1'b0, 12'h022, 32'h00008001, 32'h0, 1'b0, 1'b1);
    issue(1'b0, H, 1'b1, 12'h022, 32'h0, 32'hFFFF8001, 1'b0, 1'b1);
    issue(1'b0, H, 1'b0, 12'h020, 32'h0, 32'h00000000, 1'b0, 1'b1);
    drain();

    // backpressure: response held stable, then back-to-back loads
    resp_ready = 1'b0;
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_resp_rdata", resp_rdata, 32'h80ADBEEF);
      chk("stall_resp_fault", 32'(resp_fault), 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    issue(1'b0, W, 1'b0, 12'h020, 32'h0, 32'h80010000, 1'b0, 1'b1);
    issue(1'b0, B, 1'b1, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, H, 1'b0, 12'h022, 32'h0, 32'h00008001, 1'b0, 1'b1);
    drain();
    n = pop_cyc.size();
    chk("b2b_spacing", (n >= 4) ? 32'(pop_cyc[n-1] - pop_cyc[n-4]) : 32'hFFFFFFFF, 32'd3);

`ifdef DMEM_FAULT_EN
    issue(1'b1, W, 1'b0, 12'h011, 32'h12345678, 32'h0, 1'b1, 1'b1);
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);
    issue(1'b0, H, 1'b1, 12'h021, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, R, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    issue(1'b0, W, 1'b0, 12'h013, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);
    issue(1'b0, R, 1'b0, 12'h012, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);
    issue(1'b1, H, 1'b0, 12'h021, 32'h00001234, 32'h0, 1'b0, 1'b1);
    issue(1'b0, W, 1'b0, 12'h020, 32'h0, 32'h80011234, 1'b0, 1'b1);
    issue(1'b0, H, 1'b0, 12'h023, 32'h0, 32'h00008001, 1'b0, 1'b1);
`endif

    // reset while a response is pending; concurrent store must be dropped
    issue(1'b1, W, 1'b0, 12'h040, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    drain();
    resp_ready = 1'b0;
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = W; req_addr = 12'h040; req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    issue(1'b0, W, 1'b0, 12'h040, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    issue(1'b0, W, 1'b0, 12'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b1);
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
